// File: rtl/machine_timer.sv
// Machine timer: 64-bit mtime counter with prescaler, 64-bit compare register,
// optional periodic auto-reload and a write-one-to-clear pending flag. The flag
// drives timer_irq through one register stage.
module machine_timer #(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    output logic        timer_irq,
    output logic [63:0] mtime_out
);

    // Register word indices (bus_addr[4:2]).
    localparam logic [2:0] REG_MTIME_LO = 3'd0;
    localparam logic [2:0] REG_MTIME_HI = 3'd1;
    localparam logic [2:0] REG_CMP_LO   = 3'd2;
    localparam logic [2:0] REG_CMP_HI   = 3'd3;
    localparam logic [2:0] REG_CTRL     = 3'd4;
    localparam logic [2:0] REG_PERIOD   = 3'd5;
    localparam logic [2:0] REG_STATUS   = 3'd6;

    // Last prescaler count before a tick; PRESCALE is limited to 1..65535.
    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic [63:0] mtime_q,   mtime_d;
    logic [63:0] cmp_q,     cmp_d;
    logic [1:0]  ctrl_q,    ctrl_d;
    logic [31:0] period_q,  period_d;
    logic        pending_q, pending_d;
    logic        irq_q,     irq_d;
    logic [15:0] pcount_q,  pcount_d;
    logic [31:0] rdata_q,   rdata_d;
    logic        rvalid_q,  rvalid_d;

    logic        wr_s;
    logic        rd_s;
    logic [2:0]  idx_s;
    logic        en_s;
    logic        periodic_s;
    logic        tick_s;
    logic        hit_s;
    logic [31:0] rmux_s;

    // Byte-lane bits of the address do not select anything.
    logic        unused_addr_s;
    assign unused_addr_s = ^bus_addr[1:0];

    // Decode the bus strobe and derive tick / compare-hit from current state.
    always_comb begin
        wr_s       = bus_sel & bus_we;
        rd_s       = bus_sel & ~bus_we;
        idx_s      = bus_addr[4:2];
        en_s       = ctrl_q[0];
        periodic_s = ctrl_q[1];
        tick_s     = en_s & (pcount_q == PS_LAST);
        hit_s      = en_s & (mtime_q >= cmp_q);
    end

    // Prescaler: free-runs 0..PRESCALE-1 while enabled, parked at 0 otherwise.
    always_comb begin
        pcount_d = pcount_q;
        if (!en_s) begin
            pcount_d = 16'd0;
        end else if (tick_s) begin
            pcount_d = 16'd0;
        end else begin
            pcount_d = pcount_q + 16'd1;
        end
    end

    // mtime: a bus write to either half blocks the increment for that cycle.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_s && (idx_s == REG_MTIME_LO)) begin
            mtime_d[31:0] = bus_wdata;
        end else if (wr_s && (idx_s == REG_MTIME_HI)) begin
            mtime_d[63:32] = bus_wdata;
        end else if (tick_s) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
    end

    // mtimecmp: a bus write to either half blocks the periodic reload.
    always_comb begin
        cmp_d = cmp_q;
        if (wr_s && (idx_s == REG_CMP_LO)) begin
            cmp_d[31:0] = bus_wdata;
        end else if (wr_s && (idx_s == REG_CMP_HI)) begin
            cmp_d[63:32] = bus_wdata;
        end else if (hit_s && periodic_s) begin
            cmp_d = cmp_q + {32'd0, period_q};
        end else begin
            cmp_d = cmp_q;
        end
    end

    // CTRL and PERIOD are plain software registers.
    always_comb begin
        ctrl_d   = ctrl_q;
        period_d = period_q;
        if (wr_s && (idx_s == REG_CTRL)) begin
            ctrl_d = bus_wdata[1:0];
        end else if (wr_s && (idx_s == REG_PERIOD)) begin
            period_d = bus_wdata;
        end else begin
            ctrl_d   = ctrl_q;
            period_d = period_q;
        end
    end

    // Pending flag: a hit in the same cycle beats the W1C acknowledge.
    always_comb begin
        pending_d = pending_q;
        if (hit_s) begin
            pending_d = 1'b1;
        end else if (wr_s && (idx_s == REG_STATUS) && bus_wdata[0]) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        irq_d = pending_q;
    end

    // Read mux samples the pre-update register values.
    always_comb begin
        case (idx_s)
            REG_MTIME_LO: rmux_s = mtime_q[31:0];
            REG_MTIME_HI: rmux_s = mtime_q[63:32];
            REG_CMP_LO:   rmux_s = cmp_q[31:0];
            REG_CMP_HI:   rmux_s = cmp_q[63:32];
            REG_CTRL:     rmux_s = {30'd0, ctrl_q};
            REG_PERIOD:   rmux_s = period_q;
            REG_STATUS:   rmux_s = {31'd0, pending_q};
            default:      rmux_s = 32'd0;
        endcase
        rvalid_d = rd_s;
        if (rd_s) begin
            rdata_d = rmux_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            mtime_q   <= 64'd0;
            cmp_q     <= RESET_CMP;
            ctrl_q    <= 2'd0;
            period_q  <= 32'd0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
            pcount_q  <= 16'd0;
            rdata_q   <= 32'd0;
            rvalid_q  <= 1'b0;
        end else begin
            mtime_q   <= mtime_d;
            cmp_q     <= cmp_d;
            ctrl_q    <= ctrl_d;
            period_q  <= period_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
            pcount_q  <= pcount_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;
    assign timer_irq  = irq_q;
    assign mtime_out  = mtime_q;

endmodule

// File: tb/tb_machine_timer.sv
// Bench for machine_timer: two instances (PRESCALE=1 and PRESCALE=4) share one
// bus; a per-cycle reference model checks both, plus a constant vector table
// and directed sequences for wrap, periodic reload, W1C races and clear.
module tb_machine_timer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        bus_sel = 1'b0;
    logic        bus_we = 1'b0;
    logic [4:0]  bus_addr = 5'd0;
    logic [31:0] bus_wdata = 32'd0;

    logic [31:0] r1, r4;
    logic        rv1, rv4, irq1, irq4;
    logic [63:0] mt1, mt4;

    int n_total = 0;
    int n_pass  = 0;

    machine_timer #(.PRESCALE(1)) dut1 (
        .clk(clk), .clr(clr), .bus_sel(bus_sel), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(r1),
        .bus_rvalid(rv1), .timer_irq(irq1), .mtime_out(mt1));

    machine_timer #(.PRESCALE(4)) dut4 (
        .clk(clk), .clr(clr), .bus_sel(bus_sel), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(r4),
        .bus_rvalid(rv4), .timer_irq(irq4), .mtime_out(mt4));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] mtime;
        logic [63:0] cmp;
        bit          en;
        bit          periodic;
        logic [31:0] period;
        bit          pending;
        bit          irq;
        int          cycles_since_tick;
        logic [31:0] rdata;
        bit          rvalid;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.mtime = 64'd0; m.cmp = 64'hFFFF_FFFF_FFFF_FFFF;
        m.en = 1'b0; m.periodic = 1'b0; m.period = 32'd0;
        m.pending = 1'b0; m.irq = 1'b0; m.cycles_since_tick = 0;
        m.rdata = 32'd0; m.rvalid = 1'b0;
        return m;
    endfunction

    function automatic model_t model_step(model_t s, int presc, bit c, bit sel, bit we,
                                          logic [4:0] addr, logic [31:0] wd);
        model_t n;
        int     reg_i;
        bit     wr, rd, hit, tick;
        if (c) return model_reset();
        n     = s;
        reg_i = int'(addr) / 4;
        wr    = sel && we;
        rd    = sel && !we;
        hit   = s.en && (s.mtime >= s.cmp);
        tick  = s.en && (s.cycles_since_tick + 1 == presc);
        n.cycles_since_tick = (s.en && !tick) ? s.cycles_since_tick + 1 : 0;
        if (tick && !(wr && reg_i <= 1)) n.mtime = s.mtime + 64'd1;
        if (hit && s.periodic && !(wr && (reg_i == 2 || reg_i == 3)))
            n.cmp = s.cmp + 64'(s.period);
        if (wr) begin
            case (reg_i)
                0: n.mtime = {s.mtime[63:32], wd};
                1: n.mtime = {wd, s.mtime[31:0]};
                2: n.cmp   = {s.cmp[63:32], wd};
                3: n.cmp   = {wd, s.cmp[31:0]};
                4: begin n.en = wd[0]; n.periodic = wd[1]; end
                5: n.period = wd;
                6: if (wd[0]) n.pending = 1'b0;
                default: ;
            endcase
        end
        if (hit) n.pending = 1'b1;
        n.irq    = s.pending;
        n.rvalid = rd;
        if (rd) begin
            case (reg_i)
                0: n.rdata = s.mtime[31:0];
                1: n.rdata = s.mtime[63:32];
                2: n.rdata = s.cmp[31:0];
                3: n.rdata = s.cmp[63:32];
                4: n.rdata = {30'd0, s.periodic, s.en};
                5: n.rdata = s.period;
                6: n.rdata = {31'd0, s.pending};
                default: n.rdata = 32'd0;
            endcase
        end
        return n;
    endfunction

    model_t m1 = model_reset();
    model_t m4 = model_reset();

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock: advance models, then compare both DUTs 1 time unit after the edge.
    task automatic cycle();
        model_t n1, n4;
        n1 = model_step(m1, 1, clr, bus_sel, bus_we, bus_addr, bus_wdata);
        n4 = model_step(m4, 4, clr, bus_sel, bus_we, bus_addr, bus_wdata);
        @(posedge clk); #1;
        m1 = n1; m4 = n4;
        chk("m1_mtime",  mt1, m1.mtime);
        chk("m1_irq",    {63'd0, irq1}, {63'd0, m1.irq});
        chk("m1_rvalid", {63'd0, rv1}, {63'd0, m1.rvalid});
        chk("m1_rdata",  {32'd0, r1}, {32'd0, m1.rdata});
        chk("m4_mtime",  mt4, m4.mtime);
        chk("m4_irq",    {63'd0, irq4}, {63'd0, m4.irq});
        chk("m4_rvalid", {63'd0, rv4}, {63'd0, m4.rvalid});
        chk("m4_rdata",  {32'd0, r4}, {32'd0, m4.rdata});
    endtask

    task automatic op(bit sel, bit we, logic [4:0] addr, logic [31:0] wd);
        bus_sel = sel; bus_we = we; bus_addr = addr; bus_wdata = wd;
        cycle();
        bus_sel = 1'b0; bus_we = 1'b0; bus_addr = 5'd0; bus_wdata = 32'd0;
    endtask

    task automatic wr(logic [4:0] addr, logic [31:0] wd); op(1'b1, 1'b1, addr, wd); endtask
    task automatic rd(logic [4:0] addr); op(1'b1, 1'b0, addr, 32'd0); endtask

    task automatic clr_pulse();
        clr = 1'b1; cycle(); clr = 1'b0;
    endtask

    task automatic wait_irq1(string name);
        int k = 0;
        while (irq1 !== 1'b1 && k < 100) begin cycle(); k++; end
        chk(name, {63'd0, irq1}, 64'd1);
    endtask

    typedef struct {
        bit          sel;
        bit          we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [31:0] e_mlo;
        bit          e_irq;
        bit          e_rv;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // Vectors for the PRESCALE=1 instance straight out of reset.
        tbl[0]  = '{1, 1, 5'h0C, 32'd0,   32'd0,  0, 0, 32'd0};
        tbl[1]  = '{1, 1, 5'h08, 32'd5,   32'd0,  0, 0, 32'd0};
        tbl[2]  = '{1, 1, 5'h10, 32'd1,   32'd0,  0, 0, 32'd0};
        tbl[3]  = '{0, 0, 5'h00, 32'd0,   32'd1,  0, 0, 32'd0};
        tbl[4]  = '{0, 0, 5'h00, 32'd0,   32'd2,  0, 0, 32'd0};
        tbl[5]  = '{0, 0, 5'h00, 32'd0,   32'd3,  0, 0, 32'd0};
        tbl[6]  = '{0, 0, 5'h00, 32'd0,   32'd4,  0, 0, 32'd0};
        tbl[7]  = '{0, 0, 5'h00, 32'd0,   32'd5,  0, 0, 32'd0};
        tbl[8]  = '{0, 0, 5'h00, 32'd0,   32'd6,  0, 0, 32'd0};
        tbl[9]  = '{0, 0, 5'h00, 32'd0,   32'd7,  1, 0, 32'd0};
        tbl[10] = '{1, 1, 5'h08, 32'd100, 32'd8,  1, 0, 32'd0};
        tbl[11] = '{1, 1, 5'h18, 32'd1,   32'd9,  1, 0, 32'd0};
        tbl[12] = '{0, 0, 5'h00, 32'd0,   32'd10, 0, 0, 32'd0};
        tbl[13] = '{1, 0, 5'h00, 32'd0,   32'd11, 0, 1, 32'd10};
        tbl[14] = '{0, 0, 5'h00, 32'd0,   32'd12, 0, 0, 32'd10};
        tbl[15] = '{1, 0, 5'h18, 32'd0,   32'd13, 0, 1, 32'd0};
        tbl[16] = '{1, 0, 5'h08, 32'd0,   32'd14, 0, 1, 32'd100};

        clr = 1'b1;
        cycle(); cycle();
        clr = 1'b0;
        chk("reset_mtime",  mt1, 64'd0);
        chk("reset_irq",    {63'd0, irq1}, 64'd0);
        chk("reset_rvalid", {63'd0, rv1}, 64'd0);
        chk("reset_rdata",  {32'd0, r1}, 64'd0);

        for (int i = 0; i < 17; i++) begin
            op(tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wd);
            chk($sformatf("tbl%0d_mtime", i), mt1, {32'd0, tbl[i].e_mlo});
            chk($sformatf("tbl%0d_irq", i), {63'd0, irq1}, {63'd0, tbl[i].e_irq});
            chk($sformatf("tbl%0d_rvalid", i), {63'd0, rv1}, {63'd0, tbl[i].e_rv});
            chk($sformatf("tbl%0d_rdata", i), {32'd0, r1}, {32'd0, tbl[i].e_rd});
        end

        // Clear with a read in flight: the read is dropped.
        clr = 1'b1; bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 5'h08;
        cycle();
        clr = 1'b0; bus_sel = 1'b0;
        chk("clr_drops_read", {63'd0, rv1}, 64'd0);

        // Prescale 4: 40 enabled cycles give 10 increments, then frozen.
        wr(5'h10, 32'd1);
        repeat (40) cycle();
        wr(5'h10, 32'd0);
        chk("ps4_mtime", mt4, 64'd10);
        repeat (3) cycle();
        chk("ps4_hold", mt4, 64'd10);
        rd(5'h00);
        chk("ps4_rvalid", {63'd0, rv4}, 64'd1);
        chk("ps4_rdata", {32'd0, r4}, 64'd10);
        cycle();
        chk("ps4_rvalid_drop", {63'd0, rv4}, 64'd0);
        chk("ps4_rdata_hold", {32'd0, r4}, 64'd10);

        // 32-bit carry and 64-bit wrap.
        wr(5'h10, 32'd1);
        wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h04, 32'd0);
        chk("wr_suppresses_inc", mt1, 64'h0000_0000_FFFF_FFFF);
        cycle();
        chk("carry_to_hi", mt1, 64'h0000_0001_0000_0000);
        wr(5'h04, 32'hFFFF_FFFF);
        wr(5'h00, 32'hFFFF_FFFF);
        chk("all_ones", mt1, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        chk("wrap_zero", mt1, 64'd0);

        // Periodic reload: compare steps by PERIOD at each hit.
        clr_pulse();
        wr(5'h0C, 32'd0);
        wr(5'h08, 32'd8);
        wr(5'h14, 32'd8);
        wr(5'h10, 32'd3);
        for (int j = 0; j < 3; j++) begin
            wait_irq1($sformatf("per_irq%0d", j));
            rd(5'h08);
            chk($sformatf("per_cmp%0d", j), {32'd0, r1}, 64'(16 + 8 * j));
            wr(5'h18, 32'd1);
            cycle();
            chk($sformatf("per_ack%0d", j), {63'd0, irq1}, 64'd0);
        end

        // One-shot: ack racing a live hit keeps pending; clear drops irq.
        clr_pulse();
        wr(5'h0C, 32'd0);
        wr(5'h08, 32'd3);
        wr(5'h10, 32'd1);
        wait_irq1("os_irq");
        wr(5'h18, 32'd1);
        cycle();
        chk("w1c_vs_hit", {63'd0, irq1}, 64'd1);
        clr = 1'b1; bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 5'h18;
        cycle();
        clr = 1'b0; bus_sel = 1'b0;
        chk("clr_irq", {63'd0, irq1}, 64'd0);
        chk("clr_rvalid", {63'd0, rv1}, 64'd0);
        chk("clr_mtime", mt1, 64'd0);
        rd(5'h08);
        chk("clr_cmp_lo", {32'd0, r1}, 64'h0000_0000_FFFF_FFFF);
        rd(5'h0C);
        chk("clr_cmp_hi", {32'd0, r1}, 64'h0000_0000_FFFF_FFFF);

        // Randomized traffic against the model.
        for (int t = 0; t < 2000; t++) begin
            int unsigned r;
            int unsigned a;
            logic [31:0] d;
            r = $urandom_range(0, 99);
            a = $urandom_range(0, 7);
            case (a)
                0, 2:    d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 80));
                1, 3:    d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'd0;
                4:       d = 32'($urandom_range(0, 3)) | 32'd1 & 32'($urandom_range(0, 1) | ($urandom_range(0, 4) != 0));
                5:       d = 32'($urandom_range(0, 20));
                default: d = $urandom;
            endcase
            if (r < 2)       clr_pulse();
            else if (r < 50) cycle();
            else if (r < 70) rd(5'(a * 4 + $urandom_range(0, 3)));
            else             wr(5'(a * 4), d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
